// File: rtl/ysyx_040066_mul_ctrl.sv
// ysyx_040066_mul_ctrl: sequencing controller for a 66-bit Booth/Wallace
// multiplier datapath serving RV64M MUL/MULH/MULHSU/MULHU/MULW.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   in_valid / in_ready    request handshake from the execute stage
//   mul_op, src1, src2     operation select and 64-bit operands
//   flush                  kills the in-flight operation
//   out_valid / out_ready  result handshake
//   result                 selected 64 product bits
//   busy                   high whenever the controller is not idle
//   dp_start               one-cycle launch pulse to the datapath
//   dp_a, dp_b             66-bit extended operands for the datapath
//   dp_done, dp_prod       datapath completion pulse and low 128 product bits
//
// Build option: define YSYX_040066_MUL_ZERO_BYPASS_EN to answer requests
// with a zero operand directly (result 0) without launching the datapath.

module ysyx_040066_mul_ctrl (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [2:0]   mul_op,
   input  logic [63:0]  src1,
   input  logic [63:0]  src2,
   input  logic         flush,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [63:0]  result,
   output logic         busy,
   output logic         dp_start,
   output logic [65:0]  dp_a,
   output logic [65:0]  dp_b,
   input  logic         dp_done,
   input  logic [127:0] dp_prod
);

   localparam int unsigned XLEN = 64;
   localparam int unsigned DW   = 66;
   localparam int unsigned HW   = 32;

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_MULHU  = 3'b011;
   localparam logic [2:0] OP_MULW   = 3'b100;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_DONE,
      S_DRAIN
   } state_t;

   state_t            state, state_n;
   logic [2:0]        op_q, op_n;
   logic [DW-1:0]     ext_a, ext_b;
   logic [XLEN-1:0]   res_sel;
   logic              hs, load_op, cap_res, clr_res;

   assign hs = in_valid && in_ready && !flush;

   // Normalise the opcode (reserved encodings run as MUL) and extend operands.
   always_comb begin
      op_n  = (mul_op > OP_MULW) ? OP_MUL : mul_op;
      ext_a = {{(DW-XLEN){src1[XLEN-1]}}, src1};
      ext_b = {{(DW-XLEN){src2[XLEN-1]}}, src2};
      case (op_n)
         OP_MULHSU: ext_b = {{(DW-XLEN){1'b0}}, src2};
         OP_MULHU: begin
            ext_a = {{(DW-XLEN){1'b0}}, src1};
            ext_b = {{(DW-XLEN){1'b0}}, src2};
         end
         OP_MULW: begin
            ext_a = {{(DW-HW){src1[HW-1]}}, src1[HW-1:0]};
            ext_b = {{(DW-HW){src2[HW-1]}}, src2[HW-1:0]};
         end
         default: ;
      endcase
   end

   // Pick the architectural result bits from the datapath product.
   always_comb begin
      case (op_q)
         OP_MULH, OP_MULHSU, OP_MULHU: res_sel = dp_prod[2*XLEN-1:XLEN];
         OP_MULW: res_sel = {{(XLEN-HW){dp_prod[HW-1]}}, dp_prod[HW-1:0]};
         default: res_sel = dp_prod[XLEN-1:0];
      endcase
   end

   // Next-state logic.
   always_comb begin
      state_n = state;
      load_op = 1'b0;
      cap_res = 1'b0;
      clr_res = 1'b0;
      case (state)
         S_IDLE: begin
            if (hs) begin
               load_op = 1'b1;
`ifdef YSYX_040066_MUL_ZERO_BYPASS_EN
               if ((op_n == OP_MULW) ? ((src1[HW-1:0] == '0) || (src2[HW-1:0] == '0))
                                     : ((src1 == '0) || (src2 == '0))) begin
                  clr_res = 1'b1;
                  state_n = S_DONE;
               end else begin
                  state_n = S_ISSUE;
               end
`else
               state_n = S_ISSUE;
`endif
            end
         end
         S_ISSUE: state_n = flush ? S_DRAIN : S_WAIT;
         S_WAIT: begin
            // A flush that lands with dp_done has nothing left to drain.
            if (dp_done) begin
               if (flush) begin
                  state_n = S_IDLE;
               end else begin
                  cap_res = 1'b1;
                  state_n = S_DONE;
               end
            end else if (flush) begin
               state_n = S_DRAIN;
            end
         end
         S_DONE:  if (flush || out_ready) state_n = S_IDLE;
         S_DRAIN: if (dp_done) state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   // State, registered status outputs and datapath operand/result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         in_ready  <= 1'b1;
         busy      <= 1'b0;
         out_valid <= 1'b0;
         dp_start  <= 1'b0;
         op_q      <= '0;
         dp_a      <= '0;
         dp_b      <= '0;
         result    <= '0;
      end else begin
         state     <= state_n;
         in_ready  <= (state_n == S_IDLE);
         busy      <= (state_n != S_IDLE);
         out_valid <= (state_n == S_DONE);
         dp_start  <= (state_n == S_ISSUE);
         if (load_op) begin
            op_q <= op_n;
            dp_a <= ext_a;
            dp_b <= ext_b;
         end
         if (cap_res) begin
            result <= res_sel;
         end else if (clr_res) begin
            result <= '0;
         end
      end
   end

endmodule

// File: tb/tb_ysyx_040066_mul_ctrl.sv
module tb_ysyx_040066_mul_ctrl;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [2:0]   mul_op = 3'b000;
   logic [63:0]  src1 = '0;
   logic [63:0]  src2 = '0;
   logic         flush = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [63:0]  result;
   logic         busy;
   logic         dp_start;
   logic [65:0]  dp_a;
   logic [65:0]  dp_b;
   logic         dp_done = 1'b0;
   logic [127:0] dp_prod = '0;

   int n_vec = 0;
   int n_err = 0;
   logic [63:0] sb[$];

   ysyx_040066_mul_ctrl dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .mul_op(mul_op), .src1(src1), .src2(src2), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .result(result),
      .busy(busy), .dp_start(dp_start), .dp_a(dp_a), .dp_b(dp_b),
      .dp_done(dp_done), .dp_prod(dp_prod)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h required %h", name, got, exp);
      end
   endtask

   // Signed 66x66 multiply standing in for the Booth/Wallace datapath.
   function automatic logic [127:0] dp_model(input logic [65:0] a, input logic [65:0] b);
      logic signed [131:0] p;
      p = $signed({{66{a[65]}}, a}) * $signed({{66{b[65]}}, b});
      return p[127:0];
   endfunction

   // Scoreboard monitor: compares every accepted result with the queue head.
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_out: got result %h required no out_valid", result);
            end else begin
               check("result", {64'h0, result}, {64'h0, sb.pop_front()});
            end
         end
      end
   end

   // Present a request at a negedge; returns one negedge after the handshake.
   task automatic send(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
      int k;
      in_valid = 1'b1;
      mul_op   = op;
      src1     = a;
      src2     = b;
      k = 0;
      while (!in_ready && k < 20) begin
         @(negedge clk);
         k++;
      end
      check("accept_timeout", {127'h0, k < 20}, 128'h1);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Act as the datapath: expect dp_start now, answer after lat cycles.
   task automatic serve(input int lat, input bit chk, input logic [65:0] exp_a, input logic [65:0] exp_b);
      logic [127:0] p;
      check("dp_start_latency", {127'h0, dp_start}, 128'h1);
      if (chk) begin
         check("dp_a", {62'h0, dp_a}, {62'h0, exp_a});
         check("dp_b", {62'h0, dp_b}, {62'h0, exp_b});
      end
      p = dp_model(dp_a, dp_b);
      @(negedge clk);
      check("dp_start_pulse", {127'h0, dp_start}, 128'h0);
      repeat (lat - 1) @(negedge clk);
      dp_done = 1'b1;
      dp_prod = p;
      @(negedge clk);
      dp_done = 1'b0;
   endtask

   task automatic drain_sb();
      int k;
      k = 0;
      while (sb.size() != 0 && k < 30) begin
         @(negedge clk);
         k++;
      end
      check("result_timeout", {127'h0, k < 30}, 128'h1);
      @(negedge clk);
   endtask

   task automatic wait_out_valid();
      int k;
      k = 0;
      while (!out_valid && k < 20) begin
         @(negedge clk);
         k++;
      end
      check("out_valid_timeout", {127'h0, k < 20}, 128'h1);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check("rst_in_ready", {127'h0, in_ready}, 128'h1);
      check("rst_out_valid", {127'h0, out_valid}, 128'h0);
      check("rst_busy", {127'h0, busy}, 128'h0);
      check("rst_dp_start", {127'h0, dp_start}, 128'h0);
      check("rst_result", {64'h0, result}, 128'h0);
      check("rst_dp_a", {62'h0, dp_a}, 128'h0);
      rst = 1'b0;
      @(negedge clk);

      // MUL -1 * 3
      sb.push_back(64'hFFFF_FFFF_FFFF_FFFD);
      send(3'b000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3);
      serve(2, 1'b1, 66'h3_FFFF_FFFF_FFFF_FFFF, 66'h0_0000_0000_0000_0003);
      drain_sb();
      // MULH / MULHU with 0x8000...0
      sb.push_back(64'h4000_0000_0000_0000);
      send(3'b001, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
      serve(1, 1'b1, 66'h3_8000_0000_0000_0000, 66'h3_8000_0000_0000_0000);
      drain_sb();
      sb.push_back(64'h4000_0000_0000_0000);
      send(3'b011, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
      serve(1, 1'b1, 66'h0_8000_0000_0000_0000, 66'h0_8000_0000_0000_0000);
      drain_sb();
      // MULW 0x7FFFFFFF * 2 (upper source bits must be ignored)
      sb.push_back(64'hFFFF_FFFF_FFFF_FFFE);
      send(3'b100, 64'hABCD_0000_7FFF_FFFF, 64'h0000_0001_0000_0002);
      serve(3, 1'b1, 66'h0_0000_0000_7FFF_FFFF, 66'h0_0000_0000_0000_0002);
      drain_sb();
      // MULHSU -1 * 2
      sb.push_back(64'hFFFF_FFFF_FFFF_FFFF);
      send(3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
      serve(1, 1'b1, 66'h3_FFFF_FFFF_FFFF_FFFF, 66'h0_0000_0000_0000_0002);
      drain_sb();
      // Reserved opcode runs as MUL
      sb.push_back(64'd35);
      send(3'b111, 64'd5, 64'd7);
      serve(1, 1'b1, 66'd5, 66'd7);
      drain_sb();

      // Backpressure in DONE, then a back-to-back request
      out_ready = 1'b0;
      sb.push_back(64'h100);
      send(3'b000, 64'h10, 64'h10);
      serve(3, 1'b0, '0, '0);
      wait_out_valid();
      for (int i = 0; i < 5; i++) begin
         check("bp_result", {64'h0, result}, 128'h100);
         check("bp_in_ready", {127'h0, in_ready}, 128'h0);
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_release_in_ready", {127'h0, in_ready}, 128'h1);
      sb.push_back(64'hFFFF_FFFF_FFFF_FFFE);
      send(3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
      serve(2, 1'b0, '0, '0);
      drain_sb();

      // Flush in WAIT, dp_done three cycles later
      send(3'b000, 64'd3, 64'd4);
      check("fl_wait_dp_start", {127'h0, dp_start}, 128'h1);
      @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("drain_busy", {127'h0, busy}, 128'h1);
      check("drain_in_ready0", {127'h0, in_ready}, 128'h0);
      @(negedge clk);
      check("drain_in_ready1", {127'h0, in_ready}, 128'h0);
      @(negedge clk);
      dp_done = 1'b1;
      dp_prod = 128'd12;
      check("drain_in_ready2", {127'h0, in_ready}, 128'h0);
      @(negedge clk);
      dp_done = 1'b0;
      check("drain_exit", {127'h0, in_ready}, 128'h1);

      // Flush coinciding with dp_done in WAIT
      send(3'b000, 64'd3, 64'd5);
      @(negedge clk);
      flush = 1'b1;
      dp_done = 1'b1;
      dp_prod = 128'd15;
      @(negedge clk);
      flush = 1'b0;
      dp_done = 1'b0;
      check("fl_done_in_ready", {127'h0, in_ready}, 128'h1);
      check("fl_done_out_valid", {127'h0, out_valid}, 128'h0);

      // Flush in ISSUE
      send(3'b000, 64'd6, 64'd7);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("fl_issue_drain", {127'h0, in_ready}, 128'h0);
      dp_done = 1'b1;
      @(negedge clk);
      dp_done = 1'b0;
      check("fl_issue_exit", {127'h0, in_ready}, 128'h1);

      // Flush in DONE drops the result
      out_ready = 1'b0;
      send(3'b000, 64'd2, 64'd3);
      serve(1, 1'b0, '0, '0);
      wait_out_valid();
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      out_ready = 1'b1;
      check("fl_dn_out_valid", {127'h0, out_valid}, 128'h0);
      check("fl_dn_in_ready", {127'h0, in_ready}, 128'h1);

      // Flush in IDLE blocks acceptance
      in_valid = 1'b1;
      flush = 1'b1;
      mul_op = 3'b000;
      src1 = 64'd1;
      src2 = 64'd1;
      @(negedge clk);
      in_valid = 1'b0;
      flush = 1'b0;
      check("fl_idle_busy", {127'h0, busy}, 128'h0);
      check("fl_idle_in_ready", {127'h0, in_ready}, 128'h1);

      // Stray dp_done in IDLE
      dp_done = 1'b1;
      @(negedge clk);
      dp_done = 1'b0;
      @(negedge clk);
      check("stray_idle", {127'h0, busy}, 128'h0);

      // Reset mid-operation, then a stray dp_done
      send(3'b000, 64'd3, 64'd3);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_in_ready", {127'h0, in_ready}, 128'h1);
      check("midrst_busy", {127'h0, busy}, 128'h0);
      check("midrst_result", {64'h0, result}, 128'h0);
      dp_done = 1'b1;
      @(negedge clk);
      dp_done = 1'b0;
      @(negedge clk);
      check("midrst_stray", {126'h0, busy, out_valid}, 128'h0);

      // Zero operand
      sb.push_back(64'h0);
      send(3'b000, 64'd5, 64'd0);
`ifdef YSYX_040066_MUL_ZERO_BYPASS_EN
      check("zero_no_dp_start", {127'h0, dp_start}, 128'h0);
      check("zero_out_valid", {127'h0, out_valid}, 128'h1);
`else
      serve(1, 1'b1, 66'd5, 66'd0);
`endif
      drain_sb();

      check("sb_empty", {96'h0, 32'(sb.size())}, 128'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ysyx_040066_mul_ctrl.md
YSYX_040066_MUL_CTRL -- requirements
Module: ysyx_040066_mul_ctrl

Interface
REQ-001 Parameters: none; the operand width is fixed at 64 bits and the datapath operand width at 66 bits.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  request valid from the execute stage.
REQ-005 in_ready  output  1  controller can accept a request this cycle.
REQ-006 mul_op  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 MULW; 101-111 are treated as MUL.
REQ-007 src1, src2  input  64 each  multiplicand and multiplier.
REQ-008 flush  input  1  kill the in-flight operation (pipeline redirect).
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 result  output  64  selected product bits.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 dp_start  output  1  one-cycle launch pulse to the Booth/Wallace multiplier datapath.
REQ-014 dp_a, dp_b  output  66 each  extended operands, held stable from dp_start until dp_done.
REQ-015 dp_done  input  1  one-cycle pulse from the datapath: dp_prod is valid.
REQ-016 dp_prod  input  128  low 128 bits of the datapath product.

Function
REQ-017 The FSM SHALL have five states: IDLE, ISSUE, WAIT, DONE and DRAIN.
REQ-018 in_ready SHALL equal (state==IDLE); a handshake occurs when in_valid && in_ready && !flush.
REQ-019 On a handshake, the block SHALL latch the op and the extended operands and then go IDLE->ISSUE.
REQ-020 Operand extension SHALL be as follows:
- Signed operands (MUL, MULH, src1 of MULHSU): bit 63 replicated into bits 65:64.
- Unsigned operands (MULHU, src2 of MULHSU): zero-extended.
- MULW: each operand is bits 31:0 sign-extended to 66 bits.
REQ-021 ISSUE SHALL assert dp_start for exactly one cycle and then go to WAIT.
REQ-022 In WAIT, dp_done SHALL capture the result into a 64-bit register and move the FSM to DONE.
REQ-023 Result selection SHALL be:
- MUL: dp_prod[63:0].
- MULH, MULHSU, MULHU: dp_prod[127:64].
- MULW: dp_prod[31:0] sign-extended to 64 bits.
REQ-024 In DONE, out_valid SHALL be 1 and result SHALL be stable until out_ready; with out_ready=1 the FSM SHALL go DONE->IDLE.
REQ-025 Back-to-back operation: a new request is accepted one cycle after the out handshake, with no combinational path from out_ready to in_ready.
REQ-026 Minimum latency from the request handshake to out_valid SHALL be 2 cycles plus the datapath latency.
REQ-027 Flush in ISSUE or WAIT SHALL go to DRAIN, except when dp_done coincides with the flush in WAIT; that case goes to IDLE.
REQ-028 Flush in DONE SHALL drop the result and go to IDLE. Flush in IDLE SHALL block acceptance that cycle.
REQ-029 DRAIN SHALL hold in_ready=0 and out_valid=0 until dp_done, then go to IDLE; the stale dp_prod is discarded.
REQ-030 dp_done seen in IDLE or DONE SHALL be ignored.

Reset
REQ-031 With rst high, on the next clock edge the block SHALL:
- enter state IDLE;
- clear the latched op, operands and result register to 0;
- drive out_valid=0, dp_start=0 and busy=0, with in_ready=1 from the following cycle.
REQ-032 Reset SHALL override flush and any handshake in the same cycle.
REQ-033 Reset mid-operation SHALL abandon the datapath operation without a drain; a later stray dp_done is ignored per REQ-030.

Configuration
REQ-034 With macro YSYX_040066_MUL_ZERO_BYPASS_EN defined, a request with src1 or src2 equal to zero (MULW: bits 31:0 equal to zero) SHALL skip ISSUE/WAIT, go IDLE->DONE with result 0 and assert no dp_start.
REQ-035 Without YSYX_040066_MUL_ZERO_BYPASS_EN, every request SHALL follow IDLE->ISSUE->WAIT->DONE.

Verification
REQ-036 MUL, src1=0xFFFFFFFFFFFFFFFF (-1), src2=3 -> dp_a=0x3_FFFF_FFFF_FFFF_FFFF and result=0xFFFFFFFFFFFFFFFD.
REQ-037 MULHU vs MULH with src1=src2=0x8000000000000000 -> MULHU result 0x4000000000000000; MULH result 0x4000000000000000, with dp_a upper bits 2'b11.
REQ-038 MULW, src1=0x7FFFFFFF, src2=2 -> result 0xFFFFFFFFFFFFFFFE; MULHSU with src1=-1, src2=2 -> result 0xFFFFFFFFFFFFFFFF.
REQ-039 Flush one cycle after dp_start with dp_done arriving 3 cycles later -> DRAIN observed, in_ready=0 until the cycle after dp_done, and no out_valid.
REQ-040 Backpressure: out_ready held 0 for 5 cycles in DONE -> result constant and in_ready=0; then out_ready=1 -> IDLE, and the next request is accepted.
REQ-041 Zero operand, src2=0: with the macro defined, out_valid 1 cycle after the handshake with dp_start never asserted; without the macro, the normal path runs with result 0.
